sysmem_bus_ram: RTL and testbench
=================================

Name: sysmem_bus_ram

Overview:
Parametrised on-chip RAM for the PicoRV32 native memory bus. It is the generalised successor of the fixed 1024x8 system memory:
- configurable depth
- 32-bit words with byte-lane write strobes
- optional output register
- address-window decode with error reporting

It sits between the PicoRV32 core and the EG BRAM primitives, and generates mem_ready itself through a small handshake state machine.

Parameters:
- ADDR_BASE, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.
- DEPTH_WORDS, 1024, number of 32-bit words; power of 2, 256..8192.
- REGMODE, 0, 0 = read data one cycle after the access (NOREG); 1 = extra output register stage (OUTREG).
- INIT_FILE, "", hex image loaded at configuration; empty means all-zero.

Ports:
- clka, input, 1, clock.
- rsta, input, 1, synchronous active-high reset.
- mem_valid, input, 1, request valid; held high until mem_ready.
- mem_addr, input, 32, byte address; bits [1:0] ignored.
- mem_wdata, input, 32, write data.
- mem_wstrb, input, 4, byte write enables; 4'b0000 means read.
- mem_ready, output, 1, single-cycle completion pulse.
- mem_rdata, output, 32, read data; valid while mem_ready is high.
- addr_err, output, 1, pulses together with mem_ready when the access was out of window.
- err_cnt, output, 16, saturating count of out-of-window accesses.

Behaviour:
- Clock and reset:
  - One clock, clka.
  - rsta is synchronous and active-high. It is sampled on the rising edge of clka; there is no asynchronous path.
- Reset values:
  - mem_ready=0, addr_err=0, mem_rdata=32'h0, err_cnt=0, FSM=IDLE.
  - RAM contents are not cleared by rsta.
- Address decode:
  - hit = (mem_addr >= ADDR_BASE) && (mem_addr < ADDR_BASE + 4*DEPTH_WORDS).
  - Word index = (mem_addr - ADDR_BASE)[log2(DEPTH_WORDS)+1:2].
- FSM states: IDLE, ACCESS, PIPE, RESP.
- IDLE:
  - If mem_valid=1, latch addr, wdata, wstrb and hit; go to ACCESS.
  - The BRAM is enabled on this edge; a write commits here.
- ACCESS:
  - If REGMODE=0, go to RESP with mem_ready=1 in the next cycle.
  - If REGMODE=1, go to PIPE.
- PIPE (REGMODE=1 only): data passes through the output register; go to RESP.
- RESP:
  - mem_ready=1 for exactly one cycle, then return to IDLE.
  - mem_valid is ignored in RESP and in the IDLE cycle right after it. The earliest next acceptance is 2 cycles after the mem_ready pulse.
- Latency, counted from the cycle mem_valid is first sampled high in IDLE (cycle 0):
  - mem_ready in cycle 2 for REGMODE=0.
  - mem_ready in cycle 3 for REGMODE=1.
  - Reads and writes have the same latency.
- Writes:
  - Only byte lanes with mem_wstrb[i]=1 are updated; other bytes are preserved.
  - mem_rdata is unchanged on a write response.
- Reads: mem_rdata is updated only on a read response and holds its value afterwards.
- Out-of-window access:
  - Writes are suppressed and reads return 32'h0.
  - mem_ready is still given at normal latency, so the core never hangs.
  - addr_err=1 in the mem_ready cycle.
  - err_cnt increments by 1 and saturates at 16'hFFFF (no wrap).
- Reset mid-operation:
  - rsta asserted in any state returns the FSM to IDLE next cycle. No mem_ready is issued for the aborted access.
  - A write that committed in its IDLE edge before rsta persists.
- Simultaneous rsta and mem_valid: reset wins; the request is not accepted.
- Address wrap: none. The last word (ADDR_BASE + 4*DEPTH_WORDS - 4) is a hit; the next byte address is a miss.
- A mem_wstrb or mem_wdata change after acceptance has no effect, because the values are latched.

Test Plan:
1. REGMODE=0, write 32'hDEADBEEF with wstrb 4'hF to ADDR_BASE+0x10, then read it back:
   - write mem_ready in cycle 2;
   - read mem_ready in cycle 2 with mem_rdata=32'hDEADBEEF.
2. Partial write over that word with wstrb 4'b0101, wdata 32'h11223344, then read -> mem_rdata=32'hDE22BE44.
3. REGMODE=1, read of preloaded word 0 (INIT_FILE word0=32'h00000093):
   - mem_ready in cycle 3, pulse width 1, mem_rdata=32'h00000093;
   - mem_valid held high does not start a second access until 2 cycles after the pulse.
4. DEPTH_WORDS=1024, ADDR_BASE=0:
   - read of 0x00000FFC is a hit, with addr_err=0;
   - write to 0x00001000 gives mem_ready with addr_err=1, err_cnt=1, and RAM is unchanged;
   - read of 0x00001000 returns 32'h0.
5. Force err_cnt to 16'hFFFE, issue 3 misses -> err_cnt=16'hFFFF, with no wrap.
6. Assert rsta in the ACCESS cycle of a read -> no mem_ready, mem_rdata=0. A following read completes normally at standard latency.

Source files
------------

// File: rtl/sysmem_bus_ram.sv
// sysmem_bus_ram: word-organised on-chip RAM for the PicoRV32 native memory bus.
// It decodes an address window, supports per-byte write strobes, and has an
// optional output register stage. The handshake FSM produces a one-cycle
// mem_ready pulse for every accepted request, including out-of-window ones,
// so the core never stalls on a bad address.
// INIT_FILE names the hex image that the BRAM configuration flow loads. An
// empty string selects an all-zero image. The RTL itself never resets the array.
module sysmem_bus_ram #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          REGMODE     = 0,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clka,
  input  logic        rsta,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        addr_err,
  output logic [15:0] err_cnt
);

  localparam int          AW     = $clog2(DEPTH_WORDS);
  localparam logic [32:0] WIN_LO = {1'b0, ADDR_BASE};
  localparam logic [32:0] WIN_HI = WIN_LO + 33'(DEPTH_WORDS * 4);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_PIPE   = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // BRAM array and its registered read port
  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] ram_dout_q;

  // FSM and response registers
  logic [1:0]  state_q,     state_d;
  logic        gap_q,       gap_d;       // IDLE cycle right after RESP: request ignored
  logic        is_write_q,  is_write_d;
  logic        hit_q,       hit_d;
  logic [31:0] pipe_q,      pipe_d;      // output register stage (REGMODE=1)
  logic        mem_ready_q, mem_ready_d;
  logic        addr_err_q,  addr_err_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic [15:0] err_cnt_q,   err_cnt_d;

  // Decode and BRAM strobes
  logic          hit_s;
  logic [AW-1:0] index_s;
  logic          accept_s;
  logic          ram_en_s;
  logic          ram_we_s;
  logic          resp_now_s;
  logic [31:0]   resp_data_s;

  // Window decode and acceptance; reset blocks the BRAM so a colliding request never commits
  always_comb begin
    hit_s    = ({1'b0, mem_addr} >= WIN_LO) && ({1'b0, mem_addr} < WIN_HI);
    index_s  = AW'((mem_addr - ADDR_BASE) >> 2);
    accept_s = mem_valid && (state_q == ST_IDLE) && !gap_q;
    ram_en_s = accept_s && !rsta;
    ram_we_s = ram_en_s && hit_s && (mem_wstrb != 4'b0000);
  end

  // BRAM: byte-lane writes and read-first registered read on the accept edge
  always_ff @(posedge clka) begin
    if (ram_en_s) begin
      ram_dout_q <= mem_q[index_s];
    end
    for (int i = 0; i < 4; i++) begin
      if (ram_we_s && mem_wstrb[i]) begin
        mem_q[index_s][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  // Handshake FSM next-state logic and request latching
  always_comb begin
    state_d    = state_q;
    gap_d      = 1'b0;
    is_write_d = is_write_q;
    hit_d      = hit_q;
    pipe_d     = pipe_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d    = ST_ACCESS;
          is_write_d = (mem_wstrb != 4'b0000);
          hit_d      = hit_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (REGMODE != 0) begin
          state_d = ST_PIPE;
          pipe_d  = ram_dout_q;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_PIPE: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        gap_d   = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Response outputs, computed one cycle early so they are registered into RESP
  always_comb begin
    resp_now_s  = (state_d == ST_RESP) && (state_q != ST_RESP);
    resp_data_s = (REGMODE != 0) ? pipe_q : ram_dout_q;
    mem_ready_d = resp_now_s;
    addr_err_d  = resp_now_s && !hit_q;
    if (resp_now_s && !hit_q && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
    if (resp_now_s && !is_write_q) begin
      mem_rdata_d = hit_q ? resp_data_s : 32'h0000_0000;
    end else begin
      mem_rdata_d = mem_rdata_q;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clka) begin
    if (rsta) begin
      state_q     <= ST_IDLE;
      gap_q       <= 1'b0;
      is_write_q  <= 1'b0;
      hit_q       <= 1'b0;
      pipe_q      <= 32'h0000_0000;
      mem_ready_q <= 1'b0;
      addr_err_q  <= 1'b0;
      mem_rdata_q <= 32'h0000_0000;
      err_cnt_q   <= 16'h0000;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      is_write_q  <= is_write_d;
      hit_q       <= hit_d;
      pipe_q      <= pipe_d;
      mem_ready_q <= mem_ready_d;
      addr_err_q  <= addr_err_d;
      mem_rdata_q <= mem_rdata_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign mem_ready = mem_ready_q;
  assign addr_err  = addr_err_q;
  assign mem_rdata = mem_rdata_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_sysmem_bus_ram.sv
// Self-checking bench for sysmem_bus_ram: a directed vector table, hold-valid
// and reset corner sequences, and randomized traffic against a word-array model.
module tb_sysmem_bus_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst1, val0, val1;
  logic [31:0] addr0, addr1, wd0, wd1;
  logic [3:0]  ws0, ws1;
  logic        rdy0, rdy1, err0, err1;
  logic [31:0] rd0, rd1;
  logic [15:0] cnt0, cnt1;

  int checks   = 0;
  int failures = 0;

  sysmem_bus_ram #(.ADDR_BASE(32'h0000_0000), .DEPTH_WORDS(1024), .REGMODE(0), .INIT_FILE("")) u_dut0 (
    .clka(clk), .rsta(rst0), .mem_valid(val0), .mem_addr(addr0), .mem_wdata(wd0),
    .mem_wstrb(ws0), .mem_ready(rdy0), .mem_rdata(rd0), .addr_err(err0), .err_cnt(cnt0)
  );

  sysmem_bus_ram #(.ADDR_BASE(32'h0000_2000), .DEPTH_WORDS(256), .REGMODE(1), .INIT_FILE("")) u_dut1 (
    .clka(clk), .rsta(rst1), .mem_valid(val1), .mem_addr(addr1), .mem_wdata(wd1),
    .mem_wstrb(ws1), .mem_ready(rdy1), .mem_rdata(rd1), .addr_err(err1), .err_cnt(cnt1)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic rdy_of(input int sel);
    return (sel == 0) ? rdy0 : rdy1;
  endfunction
  function automatic logic err_of(input int sel);
    return (sel == 0) ? err0 : err1;
  endfunction
  function automatic logic [31:0] rd_of(input int sel);
    return (sel == 0) ? rd0 : rd1;
  endfunction
  function automatic logic [15:0] cnt_of(input int sel);
    return (sel == 0) ? cnt0 : cnt1;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [31:0] a, input logic [31:0] w,
                       input logic [3:0] s);
    if (sel == 0) begin
      val0 = v; addr0 = a; wd0 = w; ws0 = s;
    end else begin
      val1 = v; addr1 = a; wd1 = w; ws1 = s;
    end
  endtask

  task automatic set_rst(input int sel, input logic r);
    if (sel == 0) rst0 = r;
    else rst1 = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int sel);
    drive(sel, 1'b0, 32'h0, 32'h0, 4'h0);
    set_rst(sel, 1'b1);
    tick();
    tick();
    set_rst(sel, 1'b0);
  endtask

  // One bus transaction. lat is the cycle of the mem_ready pulse counted from
  // the acceptance cycle (0). Two idle cycles follow before the next request.
  task automatic do_access(input int sel, input logic [31:0] a, input logic [31:0] w,
                           input logic [3:0] s, output int lat, output logic [31:0] rdata,
                           output logic err, output logic [15:0] cnt);
    lat = -1; rdata = 32'h0; err = 1'b0; cnt = 16'h0;
    drive(sel, 1'b1, a, w, s);
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (rdy_of(sel)) begin
        lat = n; rdata = rd_of(sel); err = err_of(sel); cnt = cnt_of(sel);
        break;
      end
    end
    drive(sel, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    check("ready_pulse_width", {31'h0, rdy_of(sel)}, 32'h0);
    tick();
  endtask

  // Randomized traffic checked against a word-array model of the window
  task automatic run_random(input int sel, input int count);
    logic [31:0] model [16];
    logic [31:0] last, base, lim, a, w, exp_rd;
    logic [3:0]  s;
    logic [15:0] mcnt, cnt;
    logic        miss, err;
    logic [31:0] rdata;
    int          idx, lat, exp_lat;
    base    = (sel == 0) ? 32'h0000_0000 : 32'h0000_2000;
    lim     = (sel == 0) ? 32'h0000_1000 : 32'h0000_0400;
    exp_lat = (sel == 0) ? 2 : 3;
    do_reset(sel);
    last = 32'h0; mcnt = 16'h0;
    for (int i = 0; i < 16; i++) begin
      w = $urandom;
      do_access(sel, base + 32'(i * 4), w, 4'hF, lat, rdata, err, cnt);
      model[i] = w;
      check("rnd_fill_lat", 32'(lat), 32'(exp_lat));
    end
    for (int t = 0; t < count; t++) begin
      miss = ($urandom_range(0, 3) == 0);
      idx  = $urandom_range(0, 15);
      if (!miss) begin
        a = base + 32'(idx * 4) + 32'($urandom_range(0, 3));
      end else begin
        case ($urandom_range(0, 2))
          0: a = base + lim + 32'($urandom_range(0, 255) * 4);
          1: a = (base != 32'h0) ? base - 32'h4 : 32'hFFFF_FFFC;
          default: a = 32'h8000_0000;
        endcase
      end
      w = $urandom;
      s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      if (s != 4'h0) begin
        if (!miss) begin
          for (int b = 0; b < 4; b++) begin
            if (s[b]) model[idx][8*b +: 8] = w[8*b +: 8];
          end
        end
        exp_rd = last;
      end else begin
        exp_rd = miss ? 32'h0 : model[idx];
        last   = exp_rd;
      end
      if (miss && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
      do_access(sel, a, w, s, lat, rdata, err, cnt);
      check("rnd_lat", 32'(lat), 32'(exp_lat));
      check("rnd_rdata", rdata, exp_rd);
      check("rnd_addr_err", {31'h0, err}, {31'h0, miss});
      check("rnd_err_cnt", {16'h0, cnt}, {16'h0, mcnt});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          lat, nready;
    logic [31:0] rdata, rd_at3;
    logic        err;
    logic [15:0] cnt;
    logic [9:0]  pat;

    tbl[0]  = '{32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0, 16'd0};
    tbl[1]  = '{32'h0000_0010, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 1'b0, 16'd0};
    tbl[2]  = '{32'h0000_0010, 32'h1122_3344, 4'h5, 32'hDEAD_BEEF, 1'b0, 16'd0};
    tbl[3]  = '{32'h0000_0010, 32'h0000_0000, 4'h0, 32'hDE22_BE44, 1'b0, 16'd0};
    tbl[4]  = '{32'h0000_0000, 32'h1234_5678, 4'hF, 32'hDE22_BE44, 1'b0, 16'd0};
    tbl[5]  = '{32'h0000_0FFC, 32'hA5A5_0001, 4'hF, 32'hDE22_BE44, 1'b0, 16'd0};
    tbl[6]  = '{32'h0000_0FFC, 32'h0000_0000, 4'h0, 32'hA5A5_0001, 1'b0, 16'd0};
    tbl[7]  = '{32'h0000_1000, 32'hCAFE_F00D, 4'hF, 32'hA5A5_0001, 1'b1, 16'd1};
    tbl[8]  = '{32'h0000_1000, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1, 16'd2};
    tbl[9]  = '{32'h0000_0000, 32'h0000_0000, 4'h0, 32'h1234_5678, 1'b0, 16'd2};
    tbl[10] = '{32'h0000_0013, 32'h0000_0000, 4'h0, 32'hDE22_BE44, 1'b0, 16'd2};

    drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
    rst0 = 1'b1; rst1 = 1'b1;
    tick(); tick(); tick();
    rst0 = 1'b0; rst1 = 1'b0;
    tick();

    // Reset state of both instances
    check("reset_outputs_0", {rdy0, err0, cnt0, 14'h0}, 32'h0);
    check("reset_rdata_0", rd0, 32'h0);
    check("reset_outputs_1", {rdy1, err1, cnt1, 14'h0}, 32'h0);
    check("reset_rdata_1", rd1, 32'h0);

    // Directed vectors: full/partial writes, window edges, miss suppression
    for (int i = 0; i < 11; i++) begin
      do_access(0, tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, lat, rdata, err, cnt);
      check("tbl_lat", 32'(lat), 32'd2);
      check("tbl_rdata", rdata, tbl[i].exp_rdata);
      check("tbl_addr_err", {31'h0, err}, {31'h0, tbl[i].exp_err});
      check("tbl_err_cnt", {16'h0, cnt}, {16'h0, tbl[i].exp_cnt});
    end

    // REGMODE=1: latency 3, and a held mem_valid restarts only 2 cycles after the pulse
    do_access(1, 32'h0000_2000, 32'h0000_0093, 4'hF, lat, rdata, err, cnt);
    check("reg_write_lat", 32'(lat), 32'd3);
    drive(1, 1'b1, 32'h0000_2000, 32'h0, 4'h0);
    pat = 10'h0; rd_at3 = 32'h0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      pat[n-1] = rdy1;
      if (n == 3) rd_at3 = rd1;
      if (n == 9) drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
    end
    check("reg_hold_valid_pattern", {22'h0, pat}, 32'h0000_0084);
    check("reg_read_rdata", rd_at3, 32'h0000_0093);
    tick(); tick();

    run_random(0, 150);
    run_random(1, 80);

    // Saturation of the error counter
    @(negedge clk);
    force u_dut0.err_cnt_q = 16'hFFFE;
    @(negedge clk);
    release u_dut0.err_cnt_q;
    #1;
    check("sat_preset", {16'h0, cnt0}, 32'h0000_FFFE);
    for (int i = 0; i < 3; i++) begin
      do_access(0, 32'h0000_1000, 32'h0, 4'h0, lat, rdata, err, cnt);
      check("sat_err_cnt", {16'h0, cnt}, 32'h0000_FFFF);
      check("sat_addr_err", {31'h0, err}, 32'h1);
    end

    // Reset during the ACCESS cycle aborts the read without a response
    do_access(0, 32'h0000_0100, 32'h600D_CAFE, 4'hF, lat, rdata, err, cnt);
    drive(0, 1'b1, 32'h0000_0100, 32'h0, 4'h0);
    tick();
    rst0 = 1'b1;
    drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    rst0 = 1'b0;
    nready = 0;
    for (int n = 0; n < 4; n++) begin
      if (rdy0) nready++;
      tick();
    end
    check("abort_no_ready", 32'(nready), 32'd0);
    check("abort_rdata", rd0, 32'h0);
    check("abort_err_cnt", {16'h0, cnt0}, 32'h0);
    do_access(0, 32'h0000_0100, 32'h0, 4'h0, lat, rdata, err, cnt);
    check("after_abort_lat", 32'(lat), 32'd2);
    check("after_abort_rdata", rdata, 32'h600D_CAFE);

    // Reset together with mem_valid: request dropped, write not committed
    rst0 = 1'b1;
    drive(0, 1'b1, 32'h0000_0100, 32'hBAAD_F00D, 4'hF);
    tick();
    rst0 = 1'b0;
    drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
    nready = 0;
    for (int n = 0; n < 4; n++) begin
      if (rdy0) nready++;
      tick();
    end
    check("rst_valid_no_ready", 32'(nready), 32'd0);
    do_access(0, 32'h0000_0100, 32'h0, 4'h0, lat, rdata, err, cnt);
    check("rst_valid_no_write", rdata, 32'h600D_CAFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
